// File: rtl/conv_sched_if.sv
// Handshake and data bundle between the weight loader / DMA stream and conv_sched.
// The master side drives kernels and pixels; the slave side is the sequencer.
interface conv_sched_if;
  logic        w_valid;
  logic [71:0] w_data;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        dp_ready;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [15:0] pix_col;
  logic [15:0] pix_row;
  logic        win_valid;
  logic        win_last;
  logic [71:0] kernel;
  logic        busy;
  logic        frame_done;
  logic        tlast_err;

  modport master (
    output w_valid, w_data, s_axis_tdata, s_axis_tvalid, s_axis_tlast, dp_ready,
    input  s_axis_tready, pix_valid, pix_data, pix_col, pix_row, win_valid,
           win_last, kernel, busy, frame_done, tlast_err
  );

  modport slave (
    input  w_valid, w_data, s_axis_tdata, s_axis_tvalid, s_axis_tlast, dp_ready,
    output s_axis_tready, pix_valid, pix_data, pix_col, pix_row, win_valid,
           win_last, kernel, busy, frame_done, tlast_err
  );
endinterface

// File: rtl/conv_sched.sv
// Frame sequencer for the 3x3 convolution datapath: gates the pixel stream, tags
// row/column and window completion, and swaps kernels only at frame boundaries.
module conv_sched #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_col;
  logic [15:0] r_row;
  logic        r_pixValid;
  logic [7:0]  r_pixData;
  logic [15:0] r_pixCol;
  logic [15:0] r_pixRow;
  logic        r_winValid;
  logic        r_winLast;
  logic        r_tlastErr;
  logic [71:0] r_kernel;
  logic [71:0] r_shadow;
  logic        r_pending;
  logic        w_tready;
  logic        w_xfer;
  logic        w_lastPix;
  logic        w_frameEnd;
  logic [7:0]  w_pixByte;

  assign w_pixByte  = bus.s_axis_tdata[7:0];
  assign w_tready   = ((r_state == ARMED) || (r_state == RUN)) && bus.dp_ready;
  assign w_xfer     = bus.s_axis_tvalid && w_tready;
  assign w_lastPix  = (r_col == LAST_COL) && (r_row == LAST_ROW);
  // A tlast on any transfer ends the frame early, even on the first pixel.
  assign w_frameEnd = w_xfer && (w_lastPix || bus.s_axis_tlast);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (bus.w_valid) w_next = ARMED;
      ARMED, RUN: if (w_frameEnd) w_next = DONE;
                  else if (w_xfer) w_next = RUN;
      DONE:       w_next = ARMED;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == DONE) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_xfer) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixValid <= 1'b0;
      r_pixData  <= '0;
      r_pixCol   <= '0;
      r_pixRow   <= '0;
      r_winValid <= 1'b0;
      r_winLast  <= 1'b0;
      r_tlastErr <= 1'b0;
    end else begin
      r_pixValid <= w_xfer;
      r_winValid <= w_xfer && (r_row >= 16'd2) && (r_col >= 16'd2);
      r_winLast  <= w_xfer && w_lastPix;
      if (w_xfer) begin
        r_pixData <= w_pixByte;
        r_pixCol  <= r_col;
        r_pixRow  <= r_row;
      end
      if (w_xfer && (bus.s_axis_tlast != w_lastPix)) r_tlastErr <= 1'b1;
    end
  end

  // Loads during a frame park in the shadow so the active kernel never changes mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kernel  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (bus.w_valid && r_state == RUN) begin
      r_shadow  <= bus.w_data;
      r_pending <= 1'b1;
    end else if (bus.w_valid) begin
      r_kernel  <= bus.w_data;
      r_pending <= 1'b0;
    end else if (r_state == DONE && r_pending) begin
      r_kernel  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.pix_valid     = r_pixValid;
  assign bus.pix_data      = r_pixData;
  assign bus.pix_col       = r_pixCol;
  assign bus.pix_row       = r_pixRow;
  assign bus.win_valid     = r_winValid;
  assign bus.win_last      = r_winLast;
  assign bus.kernel        = r_kernel;
  assign bus.busy          = (r_state == RUN);
  assign bus.frame_done    = (r_state == DONE);
  assign bus.tlast_err     = r_tlastErr;
endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched on a 4x3 frame: vector table, directed corner
// sequences and random traffic, all checked against a pixel-index reference model.
module tb_conv_sched;
  localparam int ImgW     = 4;
  localparam int ImgH     = 3;
  localparam int FramePix = ImgW * ImgH;
  localparam logic [71:0] KernelA = 72'h010203040506070809;
  localparam logic [71:0] KernelB = 72'h112233445566778899;

  logic clk = 1'b0;
  logic rst;
  int   numChecks = 0;
  int   numFails  = 0;
  bit   sampledTready;

  conv_sched_if bus ();

  conv_sched #(.IMG_W(ImgW), .IMG_H(ImgH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a count of accepted pixels; row/col come from division.
  bit          mHasKernel, mDoneCycle, mPending, mPixValid, mWin, mLast, mErr;
  int          mIdx, mCol, mRow;
  logic [71:0] mKernel, mShadow;
  logic [7:0]  mPixData;

  typedef struct {
    bit          tv, tl, dr, wv;
    logic [71:0] wd;
    logic [7:0]  px;
    bit          eTready, ePixValid;
    logic [15:0] eCol, eRow;
    bit          eWin, eLast, eDone;
  } vec_t;

  vec_t vecs[FramePix + 1];

  task automatic compare(input string name, input logic [71:0] act, input logic [71:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mHasKernel = 0; mDoneCycle = 0; mPending = 0; mPixValid = 0;
    mWin = 0; mLast = 0; mErr = 0; mIdx = 0; mCol = 0; mRow = 0;
    mKernel = '0; mShadow = '0; mPixData = '0;
  endtask

  task automatic checkOutput();
    compare("pix_valid",  72'(bus.pix_valid),  72'(mPixValid));
    compare("pix_data",   72'(bus.pix_data),   72'(mPixData));
    compare("pix_col",    72'(bus.pix_col),    72'(mCol));
    compare("pix_row",    72'(bus.pix_row),    72'(mRow));
    compare("win_valid",  72'(bus.win_valid),  72'(mWin));
    compare("win_last",   72'(bus.win_last),   72'(mLast));
    compare("kernel",     bus.kernel,          mKernel);
    compare("busy",       72'(bus.busy),       72'(mHasKernel && !mDoneCycle && mIdx > 0));
    compare("frame_done", 72'(bus.frame_done), 72'(mDoneCycle));
    compare("tlast_err",  72'(bus.tlast_err),  72'(mErr));
  endtask

  // Drives one cycle of inputs, checks tready, advances the model and checks outputs.
  task automatic applyStimulus(input bit tv, input bit tl, input bit dr, input bit wv,
                               input logic [71:0] wd, input logic [7:0] px);
    logic [31:0] tdata;
    bit expReady, xfer, inRun, isLast, nextDone;
    tdata = $urandom();
    tdata[7:0] = px;
    bus.s_axis_tdata  = tdata;
    bus.s_axis_tvalid = tv;
    bus.s_axis_tlast  = tl;
    bus.dp_ready      = dr;
    bus.w_valid       = wv;
    bus.w_data        = wd;
    #2;
    expReady = mHasKernel && !mDoneCycle && dr;
    sampledTready = bus.s_axis_tready;
    compare("tready", 72'(bus.s_axis_tready), 72'(expReady));
    xfer  = tv && expReady;
    inRun = mHasKernel && !mDoneCycle && mIdx > 0;
    if (wv && inRun) begin
      mShadow = wd; mPending = 1;
    end else if (wv) begin
      mKernel = wd; mPending = 0;
    end else if (mDoneCycle && mPending) begin
      mKernel = mShadow; mPending = 0;
    end
    if (wv) mHasKernel = 1;
    mPixValid = xfer; mWin = 0; mLast = 0; nextDone = 0;
    if (xfer) begin
      isLast   = (mIdx == FramePix - 1);
      mPixData = px;
      mCol     = mIdx % ImgW;
      mRow     = mIdx / ImgW;
      mWin     = (mRow >= 2) && (mCol >= 2);
      mLast    = isLast;
      if (tl != isLast) mErr = 1;
      if (isLast || tl) begin
        nextDone = 1; mIdx = 0;
      end else begin
        mIdx++;
      end
    end
    mDoneCycle = nextDone;
    @(posedge clk); #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 1, 0, '0, 8'h00);
  endtask

  task automatic doReset(input bit tvHigh);
    rst = 1'b1;
    bus.s_axis_tvalid = tvHigh;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = 32'h0;
    bus.dp_ready      = 1'b1;
    bus.w_valid       = 1'b0;
    bus.w_data        = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    checkOutput();
    compare("rst_tready", 72'(bus.s_axis_tready), 72'd0);
  endtask

  task automatic runFrame(input int firstBeat, input int lastBeat, input int tlastBeat,
                          input int wAt, input logic [71:0] wd);
    for (int b = firstBeat; b <= lastBeat; b++)
      applyStimulus(1, b == tlastBeat, 1, b == wAt, wd, 8'(b + 16));
  endtask

  initial begin
    int sent, strobes;
    logic [95:0] r96;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, KernelA, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < FramePix; i++)
      vecs[i + 1] = '{1'b1, i == 11, 1'b1, 1'b0, 72'd0, 8'(i), 1'b1, 1'b1,
                      16'(i % ImgW), 16'(i / ImgW), i >= 10, i == 11, i == 11};

    doReset(0);

    // Baseline frame from the table: pixels 0..11, windows on 10 and 11 only.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].tv, vecs[k].tl, vecs[k].dr, vecs[k].wv, vecs[k].wd, vecs[k].px);
      compare("vec_tready",     72'(sampledTready),  72'(vecs[k].eTready));
      compare("vec_pix_valid",  72'(bus.pix_valid),  72'(vecs[k].ePixValid));
      compare("vec_pix_col",    72'(bus.pix_col),    72'(vecs[k].eCol));
      compare("vec_pix_row",    72'(bus.pix_row),    72'(vecs[k].eRow));
      compare("vec_win_valid",  72'(bus.win_valid),  72'(vecs[k].eWin));
      compare("vec_win_last",   72'(bus.win_last),   72'(vecs[k].eLast));
      compare("vec_frame_done", 72'(bus.frame_done), 72'(vecs[k].eDone));
    end
    compare("vec_tlast_err", 72'(bus.tlast_err), 72'd0);
    compare("vec_kernel", bus.kernel, KernelA);
    idleCycle();
    compare("done_tready", 72'(sampledTready), 72'd0);

    // dp_ready toggling with tvalid held: pixels must come out once each, in order.
    sent = 0; strobes = 0;
    for (int c = 0; c < 40 && sent < FramePix; c++) begin
      applyStimulus(1, sent == FramePix - 1, (c % 2) == 0, 0, '0, 8'(sent));
      compare("toggle_tready", 72'(sampledTready), 72'((c % 2) == 0));
      if ((c % 2) == 0) sent++;
      if (bus.pix_valid) begin
        compare("toggle_order", 72'(bus.pix_data), 72'(strobes));
        strobes++;
      end
    end
    compare("toggle_count", 72'(strobes), 72'(FramePix));
    idleCycle();

    // Kernel B requested mid-frame takes effect only after DONE.
    runFrame(0, 11, 11, 5, KernelB);
    compare("kb_last", 72'(bus.win_last), 72'd1);
    compare("kb_hold", bus.kernel, KernelA);
    idleCycle();
    compare("kb_swap", bus.kernel, KernelB);
    runFrame(0, 11, 11, -1, '0);
    compare("kb_frame2", bus.kernel, KernelB);
    idleCycle();

    // Early tlast on beat 7 aborts the frame; the next frame restarts at (0,0).
    doReset(0);
    applyStimulus(0, 0, 1, 1, KernelA, 8'h00);
    runFrame(0, 6, 6, -1, '0);
    compare("abort_done", 72'(bus.frame_done), 72'd1);
    compare("abort_last", 72'(bus.win_last), 72'd0);
    compare("abort_err", 72'(bus.tlast_err), 72'd1);
    idleCycle();
    runFrame(0, 0, -1, -1, '0);
    compare("abort_col0", 72'(bus.pix_col), 72'd0);
    compare("abort_row0", 72'(bus.pix_row), 72'd0);
    runFrame(1, 11, 11, -1, '0);
    idleCycle();
    compare("abort_sticky", 72'(bus.tlast_err), 72'd1);

    // Missing tlast on the last pixel: the frame still ends by count.
    doReset(0);
    applyStimulus(0, 0, 1, 1, KernelA, 8'h00);
    runFrame(0, 11, -1, -1, '0);
    compare("notlast_done", 72'(bus.frame_done), 72'd1);
    compare("notlast_last", 72'(bus.win_last), 72'd1);
    compare("notlast_err", 72'(bus.tlast_err), 72'd1);
    idleCycle();

    // Streaming before any kernel is loaded is refused.
    doReset(1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, 0, 1, 0, '0, 8'(c));
      compare("nokernel_tready", 72'(sampledTready), 72'd0);
      compare("nokernel_pix", 72'(bus.pix_valid), 72'd0);
    end

    // Reset at pixel 6 discards the frame and the kernel.
    applyStimulus(0, 0, 1, 1, KernelA, 8'h00);
    runFrame(0, 5, -1, -1, '0);
    doReset(1);
    compare("mid_kernel", bus.kernel, 72'd0);
    compare("mid_col", 72'(bus.pix_col), 72'd0);
    compare("mid_data", 72'(bus.pix_data), 72'd0);
    compare("mid_busy", 72'(bus.busy), 72'd0);
    applyStimulus(0, 0, 1, 1, KernelB, 8'h00);
    runFrame(0, 11, 11, -1, '0);
    compare("mid_clean_err", 72'(bus.tlast_err), 72'd0);
    compare("mid_clean_last", 72'(bus.win_last), 72'd1);
    idleCycle();

    // Random traffic with occasional kernel loads, stray tlasts and resets.
    doReset(0);
    for (int c = 0; c < 600; c++) begin
      bit tl;
      if ($urandom_range(0, 199) == 0) doReset($urandom_range(0, 1) == 1);
      r96 = {$urandom(), $urandom(), $urandom()};
      tl = (mIdx == FramePix - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 29) == 0);
      applyStimulus($urandom_range(0, 3) != 0, tl, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, r96[71:0], 8'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule

// File: doc/conv_sched.md
# conv_sched

Frame sequencer for the 3x3 convolution datapath. It latches the 72-bit kernel produced by the AXI-lite weight-loading slave and gates the DMA pixel stream (AXI-Stream, one 8-bit pixel per beat in tdata[7:0]) into the line-buffer/MAC datapath. It tags every pixel with its row and column, flags which pixels complete a valid 3x3 window, and marks the frame end. Kernel changes requested mid-frame are held in a shadow register and take effect only at a frame boundary.

## Interface
- IMG_W, 64: pixels per line; legal range 3..65535.
- IMG_H, 64: lines per frame; legal range 3..65535.
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- w_valid  in  1  single-cycle strobe from the weight loader; the kernel in w_data is complete.
- w_data  in  72  nine 8-bit kernel coefficients.
- s_axis_tdata  in  32  pixel in bits [7:0]; bits [31:8] ignored.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  source's end-of-frame marker.
- s_axis_tready  out  1  stream ready.
- dp_ready  in  1  datapath can accept a pixel this cycle.
- pix_valid  out  1  pixel strobe to the line buffer.
- pix_data  out  8  pixel value.
- pix_col  out  16  column of pix_data.
- pix_row  out  16  row of pix_data.
- win_valid  out  1  pix_valid and the pixel completes a full 3x3 window.
- win_last  out  1  pix_valid for the final pixel of the frame.
- kernel  out  72  active kernel, stable for the whole frame.
- busy  out  1  state is RUN.
- frame_done  out  1  one-cycle pulse at frame end.
- tlast_err  out  1  sticky tlast-mismatch flag; cleared only by rst.

## Operation
- States:
  - IDLE: no kernel loaded yet.
  - ARMED: kernel loaded, waiting for the first pixel.
  - RUN: frame in progress.
  - DONE: one cycle at frame end.
- Transitions:
  - IDLE->ARMED on w_valid.
  - ARMED->RUN on the first transfer.
  - RUN->DONE on the transfer with col=IMG_W-1 and row=IMG_H-1, or on any transfer with tlast=1.
  - DONE->ARMED unconditionally.
- Handshake:
  - s_axis_tready = (state==ARMED or RUN) and dp_ready, combinational from state and dp_ready.
  - A transfer occurs when tvalid and tready are both high.
  - tready is 0 in IDLE and in DONE.
- Counters:
  - col and row are 16-bit; both are 0 at the first pixel of a frame.
  - On each transfer, col increments; at IMG_W-1 it wraps to 0 and row increments.
  - Both counters clear in DONE.
- Output registers, loaded on each transfer:
  - pix_data <= tdata[7:0], pix_col <= col, pix_row <= row, pix_valid <= 1.
  - Otherwise pix_valid <= 0; pix_data, pix_col and pix_row hold.
  - win_valid <= transfer and row>=2 and col>=2.
  - win_last <= transfer on the last pixel.
- Kernel:
  - w_valid in IDLE, ARMED or DONE loads kernel <= w_data the next cycle.
  - w_valid in RUN loads the shadow register and sets pending.
  - In DONE, pending moves shadow into kernel and clears pending.
  - w_valid in the DONE cycle overrides the shadow (w_data wins) and clears pending.
  - A second w_valid in RUN overwrites the shadow.
- tlast checks (each sets tlast_err):
  - tlast=1 on a transfer that is not the last pixel: the frame aborts, the FSM goes to DONE, and frame_done pulses; win_last is not asserted.
  - tlast=0 on the last pixel: the frame still ends by count.
- Reset mid-frame: all state returns to reset values, the kernel is lost, the FSM returns to IDLE, and the partial frame is discarded.

## Timing
- Reset values:
  - state = IDLE.
  - s_axis_tready, pix_valid, win_valid, win_last, busy, frame_done and tlast_err = 0.
  - pix_data, pix_col, pix_row, kernel, shadow and pending = 0.
- Latency from a transfer to pix_valid is 1 cycle. Throughput is one pixel per cycle while tvalid and dp_ready are high.
- frame_done is high in the DONE cycle, which is the same cycle as win_last (or, on abort, the cycle after the tlast transfer).
- A new frame's first transfer occurs no earlier than the cycle after DONE. Minimum inter-frame gap is 1 cycle.
- dp_ready falling drops tready in the same cycle; no transfer occurs and the counters hold.
- busy = (state==RUN), registered with the state.
- A kernel load is visible on kernel one cycle after its w_valid or DONE cycle.

## Test plan
- IMG_W=4, IMG_H=3. Load kernel 72'h0102..09, then stream 12 beats of pixels 0..11 with tlast on beat 12 -> 12 pix_valid strobes; win_valid on pixels 10 and 11 only; win_last and frame_done together on pixel 11; tlast_err=0.
- Same frame with dp_ready toggling 1,0,1,0 and tvalid held high -> tready mirrors dp_ready; 12 pixels emitted in order with no duplicates; pix_col/pix_row sequence (0,0)..(3,2).
- w_valid with kernel B during pixel 5 of frame 1 -> kernel stays A through frame-1 win_last; kernel=B one cycle after DONE; frame 2 uses B.
- tlast on beat 7 of 12 -> DONE after beat 7, frame_done pulses, win_last stays 0, tlast_err=1 and stays set; the next frame restarts at (0,0).
- No tlast on beat 12 -> frame ends by count and tlast_err=1. Separately, stream before any w_valid -> tready stays 0 and no pix_valid.
- rst asserted at pixel 6 -> all outputs 0 the next cycle and state IDLE; after reload, a full frame runs cleanly.
